change_dispenser: RTL and testbench

Downstream stage of the ticket vending FSM. On a start pulse it takes the refund amount (the `returnMoney` value produced alongside `ticket`) and pays it out as physical notes, one at a time, over a valid/ack handshake with the note-ejector mechanism. Notes are issued greedily, largest first, from 1000/500/100/50 taka. When configured, it tracks per-denomination stock and reports a fault when change cannot be made.

---
 rtl/itvm_pkg.sv | 37 +++
 rtl/note_inventory.sv | 48 ++++
 rtl/change_dispenser.sv | 175 +++++++++++++++++
 tb/tb_change_dispenser.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itvm_pkg.sv
// itvm_pkg: shared types and constants for the ticket vending machine datapath.
//   note_e        - 2-bit note code presented to the note ejector.
//   NOTE_VAL_*    - face value in taka of each note code.
//   disp_state_e  - change_dispenser FSM states.
//   note_value()  - maps a note code to its face value.
package itvm_pkg;

    typedef enum logic [1:0] {
        NOTE_50   = 2'b00,
        NOTE_100  = 2'b01,
        NOTE_500  = 2'b10,
        NOTE_1000 = 2'b11
    } note_e;

    localparam int unsigned NOTE_VAL_50   = 50;
    localparam int unsigned NOTE_VAL_100  = 100;
    localparam int unsigned NOTE_VAL_500  = 500;
    localparam int unsigned NOTE_VAL_1000 = 1000;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StIssue,
        StDone,
        StFault
    } disp_state_e;

    function automatic int unsigned note_value(input note_e n);
        unique case (n)
            NOTE_50:   return NOTE_VAL_50;
            NOTE_100:  return NOTE_VAL_100;
            NOTE_500:  return NOTE_VAL_500;
            default:   return NOTE_VAL_1000;
        endcase
    endfunction

endpackage

// File: rtl/note_inventory.sv
// note_inventory: per-denomination note stock for the change dispenser.
// Only instantiated when CHANGE_DISPENSER_STOCK_EN is defined.
// Ports:
//   clk       - clock, rising edge.
//   rst       - asynchronous active-low reset; loads INIT_STOCK into every counter.
//   dec_i     - one note of note_i was taken by the ejector.
//   note_i    - note code to decrement.
//   refill_i  - reload every counter to INIT_STOCK; wins over a coincident dec_i.
//   avail_o   - bit i set when the counter for note code i is non-zero.
module note_inventory
    import itvm_pkg::*;
#(
    parameter int unsigned STOCK_W    = 8,
    parameter int unsigned INIT_STOCK = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_i,
    input  note_e      note_i,
    input  logic       refill_i,
    output logic [3:0] avail_o
);

    logic [STOCK_W-1:0] stock_q [4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else if (refill_i) begin
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else if (dec_i && (stock_q[note_i] != '0)) begin
            // Saturate at zero rather than wrap.
            stock_q[note_i] <= stock_q[note_i] - 1'b1;
        end
    end

    always_comb begin
        avail_o = '0;
        for (int i = 0; i < 4; i++) begin
            avail_o[i] = (stock_q[i] != '0);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a refund amount out as physical notes, largest first,
// one note per valid/ack handshake with the note ejector.
// Build option: define CHANGE_DISPENSER_STOCK_EN to track per-denomination stock,
// skip empty denominations and make refill functional. Undefined: unlimited stock.
// Ports:
//   clk            - clock, rising edge.
//   rst            - asynchronous active-low reset.
//   start          - one-cycle request to pay out amount (ignored while busy).
//   amount         - refund value in taka, sampled with start.
//   note_ack       - ejector accepted the current note (only looked at in ISSUE).
//   refill         - reload all stock counters (stock build only).
//   dispense_valid - a note is presented to the ejector.
//   dispense_note  - note code: 00=50, 01=100, 10=500, 11=1000.
//   busy           - high in SELECT, ISSUE and DONE.
//   done           - one-cycle pulse when payout completes.
//   fault          - held high while in FAULT.
//   remaining      - value still to be paid.
module change_dispenser
    import itvm_pkg::*;
#(
    parameter int unsigned AMT_W       = 14,
    parameter int unsigned STOCK_W     = 8,
    parameter int unsigned INIT_STOCK  = 20,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             note_ack,
    input  logic             refill,
    output logic             dispense_valid,
    output logic [1:0]       dispense_note,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    disp_state_e      state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    note_e            note_q, note_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             valid_q, busy_q, done_q, fault_q;

    logic [3:0]       avail;
    logic             take;
    note_e            sel_note;
    logic             sel_ok;

    // A note leaves the machine only on an acknowledged ISSUE cycle.
    assign take = (state_q == StIssue) && note_ack;

`ifdef CHANGE_DISPENSER_STOCK_EN
    note_inventory #(
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_note_inventory (
        .clk      (clk),
        .rst      (rst),
        .dec_i    (take),
        .note_i   (note_q),
        .refill_i (refill),
        .avail_o  (avail)
    );
`else
    // Unlimited stock: every denomination is always available.
    assign avail = 4'b1111;

    logic               unused_refill;
    logic [STOCK_W-1:0] unused_stock;
    assign unused_refill = refill;
    assign unused_stock  = STOCK_W'(INIT_STOCK);
`endif

    // Greedy pick: largest available note not exceeding the remaining value.
    always_comb begin
        sel_note = NOTE_50;
        sel_ok   = 1'b0;
        if ((rem_q >= AMT_W'(NOTE_VAL_1000)) && avail[3]) begin
            sel_note = NOTE_1000;
            sel_ok   = 1'b1;
        end else if ((rem_q >= AMT_W'(NOTE_VAL_500)) && avail[2]) begin
            sel_note = NOTE_500;
            sel_ok   = 1'b1;
        end else if ((rem_q >= AMT_W'(NOTE_VAL_100)) && avail[1]) begin
            sel_note = NOTE_100;
            sel_ok   = 1'b1;
        end else if ((rem_q >= AMT_W'(NOTE_VAL_50)) && avail[0]) begin
            sel_note = NOTE_50;
            sel_ok   = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        note_d  = note_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            StIdle, StFault: begin
                if (start) begin
                    rem_d = amount;
                    if (amount == '0) begin
                        state_d = StDone;
                    end else if ((amount % AMT_W'(NOTE_VAL_50)) != '0) begin
                        state_d = StFault;
                    end else begin
                        state_d = StSelect;
                    end
                end
            end
            StSelect: begin
                if (sel_ok) begin
                    note_d  = sel_note;
                    tmo_d   = '0;
                    state_d = StIssue;
                end else begin
                    state_d = StFault;
                end
            end
            StIssue: begin
                if (note_ack) begin
                    // Selection guarantees the note value never exceeds rem_q.
                    rem_d   = rem_q - AMT_W'(note_value(note_q));
                    state_d = (rem_d == '0) ? StDone : StSelect;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_W'(ACK_TIMEOUT)) begin
                        state_d = StFault;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            note_q  <= NOTE_50;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            note_q  <= note_d;
            tmo_q   <= tmo_d;
            valid_q <= (state_d == StIssue);
            busy_q  <= (state_d == StSelect) || (state_d == StIssue) || (state_d == StDone);
            done_q  <= (state_d == StDone);
            fault_q <= (state_d == StFault);
        end
    end

    assign dispense_valid = valid_q;
    assign dispense_note  = note_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign fault          = fault_q;
    assign remaining      = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table of payout vectors with the ack
// tied high, plus directed sequences for timeout, busy/ack-hold, async reset and,
// in the stock build, stock exhaustion and refill priority.
module tb_change_dispenser;

    localparam int unsigned AMT_W       = 14;
    localparam int unsigned STOCK_W     = 8;
    localparam int unsigned INIT_STOCK  = 1;
    localparam int unsigned ACK_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [AMT_W-1:0] amount = '0;
    logic             note_ack = 1'b0;
    logic             refill = 1'b0;
    logic             dispense_valid;
    logic [1:0]       dispense_note;
    logic             busy;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] remaining;

    int checks = 0;
    int failures = 0;

    change_dispenser #(
        .AMT_W       (AMT_W),
        .STOCK_W     (STOCK_W),
        .INIT_STOCK  (INIT_STOCK),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .amount         (amount),
        .note_ack       (note_ack),
        .refill         (refill),
        .dispense_valid (dispense_valid),
        .dispense_note  (dispense_note),
        .busy           (busy),
        .done           (done),
        .fault          (fault),
        .remaining      (remaining)
    );

    always #5 clk = ~clk;

    // notes: first issued note in [1:0], second in [3:2], ...
    typedef struct {
        logic [AMT_W-1:0] amt;
        int               n_notes;
        logic [7:0]       notes;
        bit               exp_fault;
        int               exp_k;
        logic [AMT_W-1:0] exp_rem;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the edge that sampled start (cycle N+1).
    task automatic start_txn(input logic [AMT_W-1:0] amt);
        @(negedge clk);
        amount = amt;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_refill();
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0]       seen;
        int               nseen;
        int               end_k;
        logic             got_fault;
        logic [AMT_W-1:0] end_rem;
        seen      = '0;
        nseen     = 0;
        end_k     = -1;
        got_fault = 1'b0;
        end_rem   = '0;
        do_refill();
        note_ack = 1'b1;
        start_txn(v.amt);
        check($sformatf("v%0d_busy_k1", idx), 32'(busy), 32'(!(v.exp_fault && v.exp_k == 1)));
        check($sformatf("v%0d_fault_k1", idx), 32'(fault), 32'(v.exp_fault && v.exp_k == 1));
        for (int k = 1; k <= 60; k++) begin
            if (dispense_valid) begin
                if (nseen < 4) seen[2*nseen +: 2] = dispense_note;
                nseen++;
            end
            if (done || fault) begin
                end_k     = k;
                got_fault = fault;
                end_rem   = remaining;
                break;
            end
            tick();
        end
        note_ack = 1'b0;
        check($sformatf("v%0d_note_count", idx), 32'(nseen), 32'(v.n_notes));
        check($sformatf("v%0d_note_seq", idx), 32'(seen), 32'(v.notes));
        check($sformatf("v%0d_fault_end", idx), 32'(got_fault), 32'(v.exp_fault));
        check($sformatf("v%0d_end_cycle", idx), 32'(end_k), 32'(v.exp_k));
        check($sformatf("v%0d_remaining", idx), 32'(end_rem), 32'(v.exp_rem));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int valid_cycles;
        int fault_k;
        int note_bad;
        int rem_bad;

        vecs[0] = '{amt: 14'd1650,  n_notes: 4, notes: 8'b00_01_10_11, exp_fault: 1'b0,
                    exp_k: 9, exp_rem: 14'd0};
        vecs[1] = '{amt: 14'd0,     n_notes: 0, notes: 8'b0, exp_fault: 1'b0,
                    exp_k: 1, exp_rem: 14'd0};
        vecs[2] = '{amt: 14'd120,   n_notes: 0, notes: 8'b0, exp_fault: 1'b1,
                    exp_k: 1, exp_rem: 14'd120};
        vecs[3] = '{amt: 14'd100,   n_notes: 1, notes: 8'b00_00_00_01, exp_fault: 1'b0,
                    exp_k: 3, exp_rem: 14'd0};
        vecs[4] = '{amt: 14'd50,    n_notes: 1, notes: 8'b00_00_00_00, exp_fault: 1'b0,
                    exp_k: 3, exp_rem: 14'd0};
        vecs[5] = '{amt: 14'd600,   n_notes: 2, notes: 8'b00_00_01_10, exp_fault: 1'b0,
                    exp_k: 5, exp_rem: 14'd0};
        vecs[6] = '{amt: 14'd25,    n_notes: 0, notes: 8'b0, exp_fault: 1'b1,
                    exp_k: 1, exp_rem: 14'd25};
        vecs[7] = '{amt: 14'd1150,  n_notes: 3, notes: 8'b00_00_01_11, exp_fault: 1'b0,
                    exp_k: 7, exp_rem: 14'd0};
        vecs[8] = '{amt: 14'd1550,  n_notes: 3, notes: 8'b00_00_10_11, exp_fault: 1'b0,
                    exp_k: 7, exp_rem: 14'd0};
        vecs[9] = '{amt: 14'd16383, n_notes: 0, notes: 8'b0, exp_fault: 1'b1,
                    exp_k: 1, exp_rem: 14'd16383};

        // Reset state.
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(dispense_valid), 0);
        check("rst_note", 32'(dispense_note), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_remaining", 32'(remaining), 0);
        @(negedge clk);
        rst = 1'b1;

        // Ack outside ISSUE must do nothing.
        note_ack = 1'b1;
        tick();
        tick();
        check("idle_ack_valid", 32'(dispense_valid), 0);
        check("idle_ack_busy", 32'(busy), 0);
        note_ack = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Ack timeout on 500: 15 ISSUE cycles then FAULT with the value unpaid.
        do_refill();
        note_ack = 1'b0;
        start_txn(14'd500);
        valid_cycles = 0;
        fault_k      = -1;
        note_bad     = 0;
        rem_bad      = 0;
        for (int k = 1; k <= 40; k++) begin
            if (dispense_valid) begin
                valid_cycles++;
                if (dispense_note !== 2'b10) note_bad++;
            end
            if (remaining !== 14'd500) rem_bad++;
            if (fault) begin
                fault_k = k;
                break;
            end
            tick();
        end
        check("tmo_valid_cycles", 32'(valid_cycles), ACK_TIMEOUT);
        check("tmo_note_stable", 32'(note_bad), 0);
        check("tmo_rem_stable", 32'(rem_bad), 0);
        check("tmo_fault_cycle", 32'(fault_k), 32'(2 + ACK_TIMEOUT));
        check("tmo_valid_drop", 32'(dispense_valid), 0);
        check("tmo_remaining", 32'(remaining), 500);

        // 600 from FAULT with delayed ack; a start while busy is ignored.
        do_refill();
        start_txn(14'd600);
        check("hold_fault_cleared", 32'(fault), 0);
        amount = 14'd50;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("hold_k2_valid", 32'(dispense_valid), 1);
        tick();
        check("hold_k3_remaining", 32'(remaining), 600);
        check("hold_k3_note", 32'(dispense_note), 2);
        note_ack = 1'b1;
        tick();
        check("hold_k4_remaining", 32'(remaining), 100);
        check("hold_k4_valid", 32'(dispense_valid), 0);
        tick();
        check("hold_k5_note", 32'(dispense_note), 1);
        tick();
        check("hold_k6_done", 32'(done), 1);
        check("hold_k6_remaining", 32'(remaining), 0);
        note_ack = 1'b0;
        tick();
        check("hold_k7_done_pulse", 32'(done), 0);
        check("hold_k7_busy", 32'(busy), 0);

        // Asynchronous reset in the middle of ISSUE.
        do_refill();
        note_ack = 1'b0;
        start_txn(14'd1650);
        tick();
        check("arst_pre_valid", 32'(dispense_valid), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 32'(dispense_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_remaining", 32'(remaining), 0);
        check("arst_note", 32'(dispense_note), 0);
        check("arst_done_fault", 32'({done, fault}), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        check("arst_idle_busy", 32'(busy), 0);
        check("arst_idle_done_fault", 32'({done, fault}), 0);
        run_vec(10, vecs[4]);

`ifdef CHANGE_DISPENSER_STOCK_EN
        // One note of each: 2000 pays 1000+500+100+50, then runs dry at 350.
        run_vec(11, '{amt: 14'd2000, n_notes: 4, notes: 8'b00_01_10_11, exp_fault: 1'b1,
                      exp_k: 10, exp_rem: 14'd350});

        // Refill coinciding with the ack of a 1000 note keeps that stock full.
        do_refill();
        note_ack = 1'b0;
        start_txn(14'd1000);
        tick();
        check("rfl_note_k2", 32'(dispense_note), 3);
        @(negedge clk);
        note_ack = 1'b1;
        refill   = 1'b1;
        tick();
        note_ack = 1'b0;
        refill   = 1'b0;
        check("rfl_done", 32'(done), 1);
        note_ack = 1'b1;
        start_txn(14'd1000);
        tick();
        check("rfl_second_1000", 32'(dispense_note), 3);
        tick();
        check("rfl_second_done", 32'(done), 1);
        // No refill now: the single 1000 note is gone, so 500 is chosen.
        start_txn(14'd1000);
        tick();
        check("rfl_depleted_note", 32'(dispense_note), 2);
        for (int k = 0; k < 20; k++) begin
            if (fault || done) break;
            tick();
        end
        note_ack = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
